// File: rtl/nand_cpu.sv
// Single-cycle 16-bit NAND/SHL CPU with a unified word memory (instance MEMORY).
// One instruction retires per clock; HALT freezes all state until reset.

module nand_mem #(
  parameter int ADDR_W   = 16,
  parameter int ROW_BITS = 64,
  parameter int MEM_ROWS = 2**(ADDR_W-2)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [15:0]       idata,
  input  logic [ADDR_W-1:0] daddr,
  output logic [15:0]       rdata,
  input  logic              we,
  input  logic [15:0]       wdata
);
  logic [ROW_BITS-1:0] core [MEM_ROWS];

  // Asynchronous reads see the pre-edge contents, so a same-cycle write returns old data.
  assign idata = core[iaddr[ADDR_W-1:2]][{iaddr[1:0], 4'b0000} +: 16];
  assign rdata = core[daddr[ADDR_W-1:2]][{daddr[1:0], 4'b0000} +: 16];

  always_ff @(posedge clk) begin
    if (we) begin
      core[daddr[ADDR_W-1:2]][{daddr[1:0], 4'b0000} +: 16] <= wdata;
    end
  end
endmodule

module nand_cpu #(
  parameter int ADDR_W   = 16,
  parameter int ROW_BITS = 64,
  parameter int MEM_ROWS = 2**(ADDR_W-2)
) (
  input  logic clk,
  input  logic n_rst,
  output logic halt
);
  localparam logic [3:0] OP_NAND = 4'h0;
  localparam logic [3:0] OP_SHL  = 4'h1;
  localparam logic [3:0] OP_LI   = 4'h2;
  localparam logic [3:0] OP_LUI  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_BZ   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;
  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [15:0]       regs [16];
  logic [15:0]       instr;
  logic [15:0]       dmem_rd;
  logic [3:0]        op;
  logic [3:0]        ra;
  logic [3:0]        rb;
  logic [3:0]        rc;
  logic [7:0]        imm8;
  logic [15:0]       ra_val;
  logic [15:0]       rb_val;
  logic [15:0]       rc_val;
  logic              reg_we;
  logic [15:0]       reg_wd;
  logic              mem_we;

  assign op   = instr[15:12];
  assign ra   = instr[11:8];
  assign rb   = instr[7:4];
  assign rc   = instr[3:0];
  assign imm8 = instr[7:0];

  assign ra_val = (ra == 4'd0) ? 16'h0000 : regs[ra];
  assign rb_val = (rb == 4'd0) ? 16'h0000 : regs[rb];
  assign rc_val = (rc == 4'd0) ? 16'h0000 : regs[rc];

  nand_mem #(
    .ADDR_W   (ADDR_W),
    .ROW_BITS (ROW_BITS),
    .MEM_ROWS (MEM_ROWS)
  ) MEMORY (
    .clk   (clk),
    .iaddr (pc),
    .idata (instr),
    .daddr (rb_val[ADDR_W-1:0]),
    .rdata (dmem_rd),
    .we    (mem_we),
    .wdata (ra_val)
  );

  always_comb begin
    next_pc = pc + PC_ONE;
    reg_we  = 1'b0;
    reg_wd  = 16'h0000;
    case (op)
      OP_NAND: begin reg_we = 1'b1; reg_wd = ~(rb_val & rc_val); end
      OP_SHL:  begin reg_we = 1'b1; reg_wd = {rb_val[14:0], 1'b0}; end
      OP_LI:   begin reg_we = 1'b1; reg_wd = {8'h00, imm8}; end
      OP_LUI:  begin reg_we = 1'b1; reg_wd = {imm8, ra_val[7:0]}; end
      OP_LD:   begin reg_we = 1'b1; reg_wd = dmem_rd; end
      OP_BZ:   if (ra_val == 16'h0000) next_pc = rb_val[ADDR_W-1:0];
      OP_HALT: next_pc = pc;
      default: ;
    endcase
  end

  // Reset and halt both take precedence over the store issued this cycle.
  assign mem_we = (op == OP_ST) && !n_rst && !halt;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      pc   <= '0;
      halt <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
    end else if (!halt) begin
      pc <= next_pc;
      if (op == OP_HALT) halt <= 1'b1;
      if (reg_we && ra != 4'd0) regs[ra] <= reg_wd;
    end
  end
endmodule

// File: tb/tb_nand_cpu.sv
// Directed bench for nand_cpu: table-driven program vectors plus reset, adder and reset-timing sequences.

module tb_nand_cpu;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic halt;

  int errors = 0;
  int checks = 0;

  nand_cpu dut (.clk(clk), .n_rst(n_rst), .halt(halt));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] prog [12];
    int          len;
    logic        pre_en;
    logic [15:0] pre_addr;
    logic [15:0] pre_val;
    logic [15:0] chk_addr;
    logic [15:0] exp_val;
    int          exp_edges;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] addr);
    logic [1:0] lane;
    lane = addr[1:0];
    return dut.MEMORY.core[addr[15:2]][{lane, 4'b0000} +: 16];
  endfunction

  task automatic wr(input logic [15:0] addr, input logic [15:0] val);
    logic [1:0] lane;
    lane = addr[1:0];
    dut.MEMORY.core[addr[15:2]][{lane, 4'b0000} +: 16] = val;
  endtask

  task automatic do_reset(input int n);
    n_rst = 1'b1;
    repeat (n) tick();
    n_rst = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int edges);
    edges = 0;
    while (halt !== 1'b1 && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  task automatic load_adder();
    logic [15:0] p [20];
    p = '{16'h2C00, 16'h3C01, 16'h2D01, 16'h3D01, 16'h2E02, 16'h3E01,
          16'h41D0, 16'h42C0, 16'h2A0A, 16'h2B12,
          16'h62B0, 16'h0312, 16'h0413, 16'h0523, 16'h0145, 16'h0633,
          16'h1260, 16'h60A0, 16'h51E0, 16'h7000};
    for (int i = 0; i < 20; i++) wr(16'(i), p[i]);
  endtask

  initial begin
    int edges;
    int held;
    logic [15:0] a;
    logic [15:0] b;

    // NAND / LI / ST
    vecs[0].prog[0:5] = '{16'h210F, 16'h223C, 16'h0312, 16'h2440, 16'h5340, 16'h7000};
    vecs[0].len = 6; vecs[0].pre_en = 1'b0; vecs[0].pre_addr = 16'h0; vecs[0].pre_val = 16'h0;
    vecs[0].chk_addr = 16'h0040; vecs[0].exp_val = 16'hFFF3; vecs[0].exp_edges = 6;
    // LUI / SHL / LD with MSB dropped by the shift
    vecs[1].prog[0:5] = '{16'h2441, 16'h4540, 16'h1650, 16'h36AB, 16'h5640, 16'h7000};
    vecs[1].len = 6; vecs[1].pre_en = 1'b1; vecs[1].pre_addr = 16'h0041; vecs[1].pre_val = 16'h8001;
    vecs[1].chk_addr = 16'h0041; vecs[1].exp_val = 16'hAB02; vecs[1].exp_edges = 6;
    // write to r0 is discarded, BZ r0 taken, r0 stored as 0
    vecs[2].prog[0:8] = '{16'h2005, 16'h2707, 16'h2850, 16'h6070, 16'h21EE,
                          16'h5180, 16'h7000, 16'h5080, 16'h7000};
    vecs[2].len = 9; vecs[2].pre_en = 1'b1; vecs[2].pre_addr = 16'h0050; vecs[2].pre_val = 16'h1234;
    vecs[2].chk_addr = 16'h0050; vecs[2].exp_val = 16'h0000; vecs[2].exp_edges = 6;
    // BZ on nonzero register falls through
    vecs[3].prog[0:7] = '{16'h2101, 16'h2706, 16'h2850, 16'h6170, 16'h5180,
                          16'h7000, 16'h5080, 16'h7000};
    vecs[3].len = 8; vecs[3].pre_en = 1'b1; vecs[3].pre_addr = 16'h0050; vecs[3].pre_val = 16'h1234;
    vecs[3].chk_addr = 16'h0050; vecs[3].exp_val = 16'h0001; vecs[3].exp_edges = 6;
    // reserved opcodes act as NOP
    vecs[4].prog[0:5] = '{16'h2122, 16'h8123, 16'hF111, 16'h2850, 16'h5180, 16'h7000};
    vecs[4].len = 6; vecs[4].pre_en = 1'b0; vecs[4].pre_addr = 16'h0; vecs[4].pre_val = 16'h0;
    vecs[4].chk_addr = 16'h0050; vecs[4].exp_val = 16'h0022; vecs[4].exp_edges = 6;
    // ST then LD of same word: next instruction sees the stored value
    vecs[5].prog[0:6] = '{16'h217F, 16'h2860, 16'h5180, 16'h4280, 16'h1320, 16'h5380, 16'h7000};
    vecs[5].len = 7; vecs[5].pre_en = 1'b0; vecs[5].pre_addr = 16'h0; vecs[5].pre_val = 16'h0;
    vecs[5].chk_addr = 16'h0060; vecs[5].exp_val = 16'h00FE; vecs[5].exp_edges = 7;
    // pc wrap from 0xFFFF to 0
    vecs[6].prog[0:7] = '{16'h2204, 16'h6120, 16'h5180, 16'h7000, 16'h2850,
                          16'h27FF, 16'h37FF, 16'h6070};
    vecs[6].len = 8; vecs[6].pre_en = 1'b1; vecs[6].pre_addr = 16'hFFFF; vecs[6].pre_val = 16'h2133;
    vecs[6].chk_addr = 16'h0050; vecs[6].exp_val = 16'h0033; vecs[6].exp_edges = 11;

    for (int r = 0; r < 2**14; r++) dut.MEMORY.core[r] = '0;

    // Reset / hold
    wr(16'h0000, 16'h7000);
    n_rst = 1'b1;
    tick();
    check("reset_halt_edge1", 32'(halt), 32'd0);
    tick();
    check("reset_halt_edge2", 32'(halt), 32'd0);
    n_rst = 1'b0;
    tick();
    check("halt_after_1_edge", 32'(halt), 32'd1);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (halt === 1'b1) held++;
    end
    check("halt_sticky_20", 32'(held), 32'd20);
    n_rst = 1'b1;
    tick();
    check("reset_clears_halt", 32'(halt), 32'd0);
    n_rst = 1'b0;
    tick();
    check("halt_again_after_reset", 32'(halt), 32'd1);

    // Table-driven program vectors
    for (int v = 0; v < 7; v++) begin
      for (int w = 0; w < 16; w++) wr(16'(w), 16'h0000);
      wr(16'hFFFF, 16'h0000);
      wr(vecs[v].chk_addr, 16'h0000);
      if (vecs[v].pre_en) wr(vecs[v].pre_addr, vecs[v].pre_val);
      for (int w = 0; w < vecs[v].len; w++) wr(16'(w), vecs[v].prog[w]);
      do_reset(2);
      run_to_halt(200, edges);
      check($sformatf("vec%0d_halt", v), 32'(halt), 32'd1);
      check($sformatf("vec%0d_edges", v), 32'(edges), 32'(vecs[v].exp_edges));
      check($sformatf("vec%0d_mem", v), 32'(rd(vecs[v].chk_addr)), 32'(vecs[v].exp_val));
    end

    // Store in the reset cycle must be suppressed
    for (int w = 0; w < 16; w++) wr(16'(w), 16'h0000);
    wr(16'h0000, 16'h2155); wr(16'h0001, 16'h2870); wr(16'h0002, 16'h5180); wr(16'h0003, 16'h7000);
    wr(16'h0070, 16'h0000);
    do_reset(2);
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    check("st_suppressed_by_reset", 32'(rd(16'h0070)), 32'h0);
    n_rst = 1'b0;
    run_to_halt(200, edges);
    check("st_restart_edges", 32'(edges), 32'd4);
    check("st_restart_mem", 32'(rd(16'h0070)), 32'h55);

    // Software adder over 64 pairs, starting with carry corner cases
    for (int w = 0; w < 24; w++) wr(16'(w), 16'h0000);
    for (int t = 0; t < 64; t++) begin
      case (t)
        0: begin a = 16'hFFFF; b = 16'h0001; end
        1: begin a = 16'h0000; b = 16'h0000; end
        2: begin a = 16'h8000; b = 16'h8000; end
        3: begin a = 16'hFFFF; b = 16'hFFFF; end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      load_adder();
      wr(16'h0101, a);
      wr(16'h0100, b);
      wr(16'h0102, 16'hDEAD);
      do_reset(2);
      run_to_halt(2000, edges);
      check($sformatf("add%0d_halt", t), 32'(halt), 32'd1);
      check($sformatf("add%0d_sum %h+%h", t, a, b), 32'(rd(16'h0102)), 32'(16'(a + b)));
    end

    // Reset in the middle of the adder loop
    load_adder();
    wr(16'h0101, 16'h7FFF);
    wr(16'h0100, 16'h0001);
    wr(16'h0102, 16'h0000);
    do_reset(2);
    repeat (40) tick();
    check("midrun_not_halted", 32'(halt), 32'd0);
    n_rst = 1'b1;
    tick();
    check("midrun_no_store", 32'(rd(16'h0102)), 32'h0);
    n_rst = 1'b0;
    run_to_halt(2000, edges);
    check("midrun_halt", 32'(halt), 32'd1);
    check("midrun_sum", 32'(rd(16'h0102)), 32'h8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
